// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage: ALU select codes,
// operand-select encodings and the packed ID/EX pipeline register layout.
package id_ex_operand_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 6;

  localparam logic [SEL_W-1:0] ALU_ADD  = 6'b000000;
  localparam logic [SEL_W-1:0] ALU_SLL  = 6'b000001;
  localparam logic [SEL_W-1:0] ALU_SLT  = 6'b000010;
  localparam logic [SEL_W-1:0] ALU_SLTU = 6'b000011;
  localparam logic [SEL_W-1:0] ALU_XOR  = 6'b000100;
  localparam logic [SEL_W-1:0] ALU_SRL  = 6'b000101;
  localparam logic [SEL_W-1:0] ALU_OR   = 6'b000110;
  localparam logic [SEL_W-1:0] ALU_AND  = 6'b000111;
  localparam logic [SEL_W-1:0] ALU_MUL  = 6'b001000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 6'b010000;
  // FWD group is 011xxx; the low three bits carry the sub-operation.
  localparam logic [SEL_W-1:0] ALU_FWD  = 6'b011000;

  localparam logic OP1_RS1 = 1'b0;
  localparam logic OP1_PC  = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [SEL_W-1:0]  sel;
    logic              op1_sel;
    logic              op2_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_reg_t;

  // True when a writer targets a real (non-x0) register matching the reader.
  function automatic logic nz_match(input logic we,
                                    input logic [REG_AW-1:0] wr_addr,
                                    input logic [REG_AW-1:0] rd_addr);
    return we && (wr_addr != '0) && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Per-operand EX forwarding mux: MEM (youngest) beats WB, x0 never forwards.
module fwd_select
  import id_ex_operand_stage_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);

  always_comb begin
    data_o = stored_i;
    // A load in MEM has no data yet, so it cannot be a forwarding source.
    if (nz_match(mem_reg_write_i & ~mem_mem_read_i, mem_rd_i, rs_addr_i)) begin
      data_o = mem_result_i;
    end else if (nz_match(wb_reg_write_i, wb_rd_i, rs_addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall, WB capture bypass and EX
// forwarding; drives the ALU operands and select every cycle.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ID_VALID,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [REG_AW-1:0] ID_RS1_ADDR,
  input  logic [REG_AW-1:0] ID_RS2_ADDR,
  input  logic [XLEN-1:0]   ID_RS1_DATA,
  input  logic [XLEN-1:0]   ID_RS2_DATA,
  input  logic              ID_USES_RS1,
  input  logic              ID_USES_RS2,
  input  logic [XLEN-1:0]   ID_IMM,
  input  logic [REG_AW-1:0] ID_RD_ADDR,
  input  logic [SEL_W-1:0]  ID_ALU_SELECT,
  input  logic              ID_OP1_SEL,
  input  logic              ID_OP2_SEL,
  input  logic              ID_REG_WRITE,
  input  logic              ID_MEM_READ,
  input  logic              ID_MEM_WRITE,
  input  logic              FLUSH,
  input  logic [REG_AW-1:0] MEM_RD_ADDR,
  input  logic              MEM_REG_WRITE,
  input  logic              MEM_MEM_READ,
  input  logic [XLEN-1:0]   MEM_ALU_RESULT,
  input  logic [REG_AW-1:0] WB_RD_ADDR,
  input  logic              WB_REG_WRITE,
  input  logic [XLEN-1:0]   WB_DATA,
  output logic              STALL,
  output logic              EX_VALID,
  output logic [XLEN-1:0]   EX_PC,
  output logic [XLEN-1:0]   ALU_DATA1,
  output logic [XLEN-1:0]   ALU_DATA2,
  output logic [SEL_W-1:0]  ALU_SELECT,
  output logic [XLEN-1:0]   EX_STORE_DATA,
  output logic [REG_AW-1:0] EX_RD_ADDR,
  output logic              EX_REG_WRITE,
  output logic              EX_MEM_READ,
  output logic              EX_MEM_WRITE
);

  ex_reg_t         ex_q, ex_d;
  logic            hz;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            unused_uses;

  always_comb begin
    hz = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & ID_VALID &
         ((ID_USES_RS1 & (ID_RS1_ADDR == ex_q.rd)) |
          (ID_USES_RS2 & (ID_RS2_ADDR == ex_q.rd)));
  end

  // A flush kills the dependent instruction anyway, so no need to freeze.
  assign STALL = hz & ~FLUSH;

  always_comb begin
    ex_d = '0;
    if (!(FLUSH || hz)) begin
      ex_d.valid     = ID_VALID;
      ex_d.pc        = ID_PC;
      ex_d.rs1_addr  = ID_RS1_ADDR;
      ex_d.rs2_addr  = ID_RS2_ADDR;
      // Register file reads the old value when WB writes the same cycle.
      ex_d.rs1_data  = nz_match(WB_REG_WRITE, WB_RD_ADDR, ID_RS1_ADDR) ? WB_DATA : ID_RS1_DATA;
      ex_d.rs2_data  = nz_match(WB_REG_WRITE, WB_RD_ADDR, ID_RS2_ADDR) ? WB_DATA : ID_RS2_DATA;
      ex_d.uses_rs1  = ID_USES_RS1;
      ex_d.uses_rs2  = ID_USES_RS2;
      ex_d.imm       = ID_IMM;
      ex_d.rd        = ID_RD_ADDR;
      ex_d.sel       = ID_ALU_SELECT;
      ex_d.op1_sel   = ID_OP1_SEL;
      ex_d.op2_sel   = ID_OP2_SEL;
      ex_d.reg_write = ID_VALID & ID_REG_WRITE;
      ex_d.mem_read  = ID_VALID & ID_MEM_READ;
      ex_d.mem_write = ID_VALID & ID_MEM_WRITE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_select u_fwd_rs1 (
    .rs_addr_i       (ex_q.rs1_addr),
    .stored_i        (ex_q.rs1_data),
    .mem_rd_i        (MEM_RD_ADDR),
    .mem_reg_write_i (MEM_REG_WRITE),
    .mem_mem_read_i  (MEM_MEM_READ),
    .mem_result_i    (MEM_ALU_RESULT),
    .wb_rd_i         (WB_RD_ADDR),
    .wb_reg_write_i  (WB_REG_WRITE),
    .wb_data_i       (WB_DATA),
    .data_o          (fwd_rs1)
  );

  fwd_select u_fwd_rs2 (
    .rs_addr_i       (ex_q.rs2_addr),
    .stored_i        (ex_q.rs2_data),
    .mem_rd_i        (MEM_RD_ADDR),
    .mem_reg_write_i (MEM_REG_WRITE),
    .mem_mem_read_i  (MEM_MEM_READ),
    .mem_result_i    (MEM_ALU_RESULT),
    .wb_rd_i         (WB_RD_ADDR),
    .wb_reg_write_i  (WB_REG_WRITE),
    .wb_data_i       (WB_DATA),
    .data_o          (fwd_rs2)
  );

  // Uses flags are held in the register for observability only.
  assign unused_uses = ex_q.uses_rs1 ^ ex_q.uses_rs2;

  assign EX_VALID      = ex_q.valid;
  assign EX_PC         = ex_q.pc;
  assign ALU_DATA1     = (ex_q.op1_sel == OP1_PC)  ? ex_q.pc  : fwd_rs1;
  assign ALU_DATA2     = (ex_q.op2_sel == OP2_IMM) ? ex_q.imm : fwd_rs2;
  assign ALU_SELECT    = ex_q.sel;
  assign EX_STORE_DATA = fwd_rs2;
  assign EX_RD_ADDR    = ex_q.rd;
  assign EX_REG_WRITE  = ex_q.reg_write;
  assign EX_MEM_READ   = ex_q.mem_read;
  assign EX_MEM_WRITE  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture, forwarding priority,
// load-use stall, flush/reset interaction and WB capture bypass.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              ID_VALID;
  logic [XLEN-1:0]   ID_PC;
  logic [REG_AW-1:0] ID_RS1_ADDR, ID_RS2_ADDR;
  logic [XLEN-1:0]   ID_RS1_DATA, ID_RS2_DATA;
  logic              ID_USES_RS1, ID_USES_RS2;
  logic [XLEN-1:0]   ID_IMM;
  logic [REG_AW-1:0] ID_RD_ADDR;
  logic [SEL_W-1:0]  ID_ALU_SELECT;
  logic              ID_OP1_SEL, ID_OP2_SEL;
  logic              ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic              FLUSH;
  logic [REG_AW-1:0] MEM_RD_ADDR;
  logic              MEM_REG_WRITE, MEM_MEM_READ;
  logic [XLEN-1:0]   MEM_ALU_RESULT;
  logic [REG_AW-1:0] WB_RD_ADDR;
  logic              WB_REG_WRITE;
  logic [XLEN-1:0]   WB_DATA;
  logic              STALL, EX_VALID;
  logic [XLEN-1:0]   EX_PC, ALU_DATA1, ALU_DATA2, EX_STORE_DATA;
  logic [SEL_W-1:0]  ALU_SELECT;
  logic [REG_AW-1:0] EX_RD_ADDR;
  logic              EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_operand_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .ID_IMM(ID_IMM), .ID_RD_ADDR(ID_RD_ADDR), .ID_ALU_SELECT(ID_ALU_SELECT),
    .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .FLUSH(FLUSH), .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_REG_WRITE(MEM_REG_WRITE),
    .MEM_MEM_READ(MEM_MEM_READ), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .WB_RD_ADDR(WB_RD_ADDR), .WB_REG_WRITE(WB_REG_WRITE), .WB_DATA(WB_DATA),
    .STALL(STALL), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_RD_ADDR(EX_RD_ADDR),
    .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ID_VALID = 0; ID_PC = '0; ID_RS1_ADDR = '0; ID_RS2_ADDR = '0;
    ID_RS1_DATA = '0; ID_RS2_DATA = '0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    ID_IMM = '0; ID_RD_ADDR = '0; ID_ALU_SELECT = ALU_ADD;
    ID_OP1_SEL = OP1_RS1; ID_OP2_SEL = OP2_RS2;
    ID_REG_WRITE = 0; ID_MEM_READ = 0; ID_MEM_WRITE = 0; FLUSH = 0;
    MEM_RD_ADDR = '0; MEM_REG_WRITE = 0; MEM_MEM_READ = 0; MEM_ALU_RESULT = '0;
    WB_RD_ADDR = '0; WB_REG_WRITE = 0; WB_DATA = '0;
  endtask

  // Drives an LW x<rd>, 4(x2) into ID.
  task automatic drive_load(input logic [REG_AW-1:0] rd);
    clear_inputs();
    ID_VALID = 1; ID_PC = 32'h100; ID_RS1_ADDR = 5'd2; ID_USES_RS1 = 1;
    ID_RD_ADDR = rd; ID_MEM_READ = 1; ID_REG_WRITE = 1;
    ID_OP2_SEL = OP2_IMM; ID_IMM = 32'd4; ID_ALU_SELECT = ALU_ADD;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1; ID_VALID = 1; ID_REG_WRITE = 1; ID_ALU_SELECT = ALU_XOR;
    ID_RS1_DATA = 32'h5; ID_RS1_ADDR = 5'd1; ID_USES_RS1 = 1;
    tick(); tick();
    checks++; if (EX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", EX_VALID); end
    checks++; if (EX_REG_WRITE !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0h expected 0", EX_REG_WRITE); end
    checks++; if (ALU_SELECT !== 6'b0) begin errors++; $display("FAIL reset_select: got %0h expected 0", ALU_SELECT); end
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h expected 0", STALL); end
    checks++; if (ALU_DATA1 !== 32'h0 || ALU_DATA2 !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h/%0h expected 0/0", ALU_DATA1, ALU_DATA2); end
    $display("reset: EX_VALID=%0h ALU_SELECT=%0h STALL=%0h", EX_VALID, ALU_SELECT, STALL);
    RESET = 0;
  endtask

  task automatic test_plain_capture();
    clear_inputs();
    ID_VALID = 1; ID_PC = 32'h40; ID_RS1_ADDR = 5'd5; ID_RS1_DATA = 32'h10;
    ID_RS2_ADDR = 5'd6; ID_RS2_DATA = 32'h22; ID_USES_RS1 = 1; ID_USES_RS2 = 1;
    ID_RD_ADDR = 5'd8; ID_REG_WRITE = 1; ID_ALU_SELECT = ALU_ADD;
    tick();
    checks++; if (EX_VALID !== 1'b1) begin errors++; $display("FAIL capture_valid: got %0h expected 1", EX_VALID); end
    checks++; if (ALU_DATA1 !== 32'h10) begin errors++; $display("FAIL capture_data1: got %0h expected 10", ALU_DATA1); end
    checks++; if (ALU_DATA2 !== 32'h22) begin errors++; $display("FAIL capture_data2: got %0h expected 22", ALU_DATA2); end
    checks++; if (ALU_SELECT !== 6'b000000) begin errors++; $display("FAIL capture_select: got %0h expected 0", ALU_SELECT); end
    checks++; if (EX_RD_ADDR !== 5'd8 || EX_REG_WRITE !== 1'b1 || EX_PC !== 32'h40) begin errors++; $display("FAIL capture_ctrl: got rd=%0d rw=%0h pc=%0h expected rd=8 rw=1 pc=40", EX_RD_ADDR, EX_REG_WRITE, EX_PC); end
    $display("capture ADD: DATA1=%0h DATA2=%0h SELECT=%0h", ALU_DATA1, ALU_DATA2, ALU_SELECT);
    // AUIPC-style: PC as op1, SUB select passed through unchanged.
    ID_OP1_SEL = OP1_PC; ID_ALU_SELECT = ALU_SUB; ID_PC = 32'h1234_5678;
    tick();
    checks++; if (ALU_DATA1 !== 32'h1234_5678 || ALU_SELECT !== 6'b010000) begin errors++; $display("FAIL capture_pc_sub: got %0h sel %0h expected 12345678 sel 10", ALU_DATA1, ALU_SELECT); end
    $display("capture PC/SUB: DATA1=%0h SELECT=%0h", ALU_DATA1, ALU_SELECT);
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 5'd7; ID_RS1_DATA = 32'h1; ID_USES_RS1 = 1;
    ID_RS2_ADDR = 5'd7; ID_RS2_DATA = 32'h2; ID_USES_RS2 = 1;
    ID_OP2_SEL = OP2_IMM; ID_IMM = 32'h99; ID_MEM_WRITE = 1;
    tick();
    ID_VALID = 0;
    MEM_RD_ADDR = 5'd7; MEM_REG_WRITE = 1; MEM_ALU_RESULT = 32'hAAAA_0000;
    WB_RD_ADDR = 5'd7; WB_REG_WRITE = 1; WB_DATA = 32'h1234;
    #1;
    checks++; if (ALU_DATA1 !== 32'hAAAA_0000) begin errors++; $display("FAIL fwd_mem_priority: got %0h expected aaaa0000", ALU_DATA1); end
    checks++; if (ALU_DATA2 !== 32'h99 || EX_STORE_DATA !== 32'hAAAA_0000) begin errors++; $display("FAIL fwd_store: got d2=%0h st=%0h expected 99/aaaa0000", ALU_DATA2, EX_STORE_DATA); end
    $display("fwd MEM+WB: DATA1=%0h STORE=%0h", ALU_DATA1, EX_STORE_DATA);
    MEM_REG_WRITE = 0; #1;
    checks++; if (ALU_DATA1 !== 32'h1234) begin errors++; $display("FAIL fwd_wb: got %0h expected 1234", ALU_DATA1); end
    $display("fwd WB only: DATA1=%0h", ALU_DATA1);
    MEM_REG_WRITE = 1; MEM_MEM_READ = 1; #1;
    checks++; if (ALU_DATA1 !== 32'h1234) begin errors++; $display("FAIL fwd_mem_load_skip: got %0h expected 1234", ALU_DATA1); end
    $display("fwd MEM load skipped: DATA1=%0h", ALU_DATA1);
    WB_REG_WRITE = 0; MEM_REG_WRITE = 0; MEM_MEM_READ = 0; #1;
    checks++; if (ALU_DATA1 !== 32'h1) begin errors++; $display("FAIL fwd_none: got %0h expected 1", ALU_DATA1); end
    // rs1 = x0 with both sources claiming x0: stored value wins.
    ID_VALID = 1; ID_RS1_ADDR = 5'd0; ID_RS1_DATA = 32'h0; ID_RS2_ADDR = 5'd0;
    tick();
    ID_VALID = 0;
    MEM_RD_ADDR = 5'd0; MEM_REG_WRITE = 1; WB_RD_ADDR = 5'd0; WB_REG_WRITE = 1;
    #1;
    checks++; if (ALU_DATA1 !== 32'h0) begin errors++; $display("FAIL fwd_x0: got %0h expected 0", ALU_DATA1); end
    $display("fwd x0: DATA1=%0h", ALU_DATA1);
  endtask

  task automatic test_load_use();
    drive_load(5'd3);
    tick();
    clear_inputs();
    ID_VALID = 1; ID_PC = 32'h104; ID_RS1_ADDR = 5'd3; ID_USES_RS1 = 1;
    ID_RD_ADDR = 5'd4; ID_REG_WRITE = 1; ID_OP2_SEL = OP2_IMM; ID_IMM = 32'd5;
    #1;
    checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %0h expected 1", STALL); end
    $display("load-use: STALL=%0h", STALL);
    tick();
    MEM_RD_ADDR = 5'd3; MEM_REG_WRITE = 1; MEM_MEM_READ = 1; MEM_ALU_RESULT = 32'h104;
    #1;
    checks++; if (EX_VALID !== 1'b0 || STALL !== 1'b0 || EX_REG_WRITE !== 1'b0) begin errors++; $display("FAIL loaduse_bubble: got v=%0h st=%0h rw=%0h expected 0/0/0", EX_VALID, STALL, EX_REG_WRITE); end
    $display("load-use bubble: EX_VALID=%0h STALL=%0h", EX_VALID, STALL);
    tick();
    MEM_REG_WRITE = 0; MEM_MEM_READ = 0;
    WB_RD_ADDR = 5'd3; WB_REG_WRITE = 1; WB_DATA = 32'hDEAD;
    #1;
    checks++; if (EX_VALID !== 1'b1 || ALU_DATA1 !== 32'hDEAD || ALU_DATA2 !== 32'd5) begin errors++; $display("FAIL loaduse_resume: got v=%0h d1=%0h d2=%0h expected 1/dead/5", EX_VALID, ALU_DATA1, ALU_DATA2); end
    $display("load-use resume: DATA1=%0h DATA2=%0h", ALU_DATA1, ALU_DATA2);
    // Both operands depend on the load: still one stall cycle.
    drive_load(5'd3);
    tick();
    clear_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 5'd3; ID_RS2_ADDR = 5'd3; ID_USES_RS1 = 1; ID_USES_RS2 = 1;
    #1;
    checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL both_stall: got %0h expected 1", STALL); end
    tick();
    checks++; if (STALL !== 1'b0 || EX_VALID !== 1'b0) begin errors++; $display("FAIL both_single: got st=%0h v=%0h expected 0/0", STALL, EX_VALID); end
    $display("both-rs hazard: single stall");
    // Load into x0 never stalls.
    drive_load(5'd0);
    tick();
    clear_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 5'd0; ID_USES_RS1 = 1;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL x0_nostall: got %0h expected 0", STALL); end
    $display("x0 load: STALL=%0h", STALL);
  endtask

  task automatic test_flush_vs_hazard();
    drive_load(5'd3);
    tick();
    clear_inputs();
    ID_VALID = 1; ID_RS2_ADDR = 5'd3; ID_USES_RS2 = 1; ID_REG_WRITE = 1;
    ID_RD_ADDR = 5'd6; ID_ALU_SELECT = ALU_OR; FLUSH = 1;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h expected 0", STALL); end
    tick();
    checks++; if (EX_VALID !== 1'b0 || EX_REG_WRITE !== 1'b0 || ALU_SELECT !== 6'b0 || EX_RD_ADDR !== 5'd0) begin errors++; $display("FAIL flush_bubble: got v=%0h rw=%0h sel=%0h rd=%0d expected 0/0/0/0", EX_VALID, EX_REG_WRITE, ALU_SELECT, EX_RD_ADDR); end
    $display("flush+hazard: bubble loaded, STALL=%0h", STALL);
    // Reset while stalled clears EX and drops STALL.
    drive_load(5'd3);
    tick();
    clear_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 5'd3; ID_USES_RS1 = 1;
    #1;
    checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL rst_stall_pre: got %0h expected 1", STALL); end
    RESET = 1;
    tick();
    RESET = 0; #1;
    checks++; if (STALL !== 1'b0 || EX_VALID !== 1'b0 || EX_MEM_READ !== 1'b0) begin errors++; $display("FAIL rst_stall_post: got st=%0h v=%0h mr=%0h expected 0/0/0", STALL, EX_VALID, EX_MEM_READ); end
    $display("reset during stall: STALL=%0h EX_VALID=%0h", STALL, EX_VALID);
  endtask

  task automatic test_wb_bypass();
    clear_inputs();
    ID_VALID = 1; ID_RS1_ADDR = 5'd9; ID_RS1_DATA = 32'h0; ID_USES_RS1 = 1;
    ID_OP2_SEL = OP2_IMM; ID_IMM = 32'hFFFF_FFFC; ID_RD_ADDR = 5'd10; ID_REG_WRITE = 1;
    WB_RD_ADDR = 5'd9; WB_REG_WRITE = 1; WB_DATA = 32'h55;
    tick();
    WB_REG_WRITE = 0; WB_DATA = 32'h0; ID_VALID = 0;
    #1;
    checks++; if (ALU_DATA1 !== 32'h55) begin errors++; $display("FAIL wb_bypass_d1: got %0h expected 55", ALU_DATA1); end
    checks++; if (ALU_DATA2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wb_bypass_d2: got %0h expected fffffffc", ALU_DATA2); end
    $display("wb bypass: DATA1=%0h DATA2=%0h", ALU_DATA1, ALU_DATA2);
  endtask

  initial begin
    clear_inputs();
    RESET = 1;
    test_reset();
    test_plain_capture();
    test_fwd_priority();
    test_load_use();
    test_flush_vs_hazard();
    test_wb_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the RV32IM core. It latches decoded instructions and produces the ALU inputs DATA1, DATA2 and SELECT.
- It also contains the EX-stage forwarding muxes, the WB→ID capture bypass and load-use hazard detection.
- It sits directly upstream of the ALU and drives it every cycle.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- SEL_W, 6, ALU SELECT width.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- ID_VALID  in  1  decoded instruction present in ID
- ID_PC  in  XLEN  instruction PC
- ID_RS1_ADDR, ID_RS2_ADDR  in  REG_AW  source register numbers
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register file read data
- ID_USES_RS1, ID_USES_RS2  in  1  instruction actually reads rs1 / rs2
- ID_IMM  in  XLEN  sign-extended immediate
- ID_RD_ADDR  in  REG_AW  destination register
- ID_ALU_SELECT  in  SEL_W  ALU operation code
- ID_OP1_SEL  in  1  0 = rs1, 1 = PC
- ID_OP2_SEL  in  1  0 = rs2, 1 = imm
- ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE  in  1  control bits
- FLUSH  in  1  redirect from branch resolution; kills the ID instruction
- MEM_RD_ADDR  in  REG_AW, MEM_REG_WRITE  in  1, MEM_MEM_READ  in  1, MEM_ALU_RESULT  in  XLEN  EX/MEM forwarding source
- WB_RD_ADDR  in  REG_AW, WB_REG_WRITE  in  1, WB_DATA  in  XLEN  MEM/WB forwarding source
- STALL  out  1  freeze PC and IF/ID (combinational)
- EX_VALID  out  1  registered valid
- EX_PC  out  XLEN  registered PC
- ALU_DATA1, ALU_DATA2  out  XLEN  to ALU DATA1 / DATA2
- ALU_SELECT  out  SEL_W  to ALU SELECT
- EX_STORE_DATA  out  XLEN  forwarded rs2 for stores
- EX_RD_ADDR  out  REG_AW; EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out  1

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high.
- Reset values: every registered field is 0, so EX_VALID=0, all EX_* controls are 0 and ALU_SELECT=6'b000000.
- Combinational outputs after reset: ALU_DATA1=0, ALU_DATA2=0 (with no forwarding match) and STALL=0.
- Registered fields: valid, PC, rs1/rs2 address, rs1/rs2 data, uses flags, imm, rd, select, op sels and the three control bits.
- Load-use hazard HZ = EX_VALID & EX_MEM_READ & EX_RD_ADDR≠0 & ID_VALID & ((ID_USES_RS1 & ID_RS1_ADDR==EX_RD_ADDR) | (ID_USES_RS2 & ID_RS2_ADDR==EX_RD_ADDR)).
- STALL = HZ & ~FLUSH.
- Update at each posedge, in priority order:
  - RESET → clear.
  - FLUSH or HZ → load bubble: valid=0, REG_WRITE/MEM_READ/MEM_WRITE=0, select=0, rd=0. Data fields don't-care but driven to 0.
  - Otherwise → capture ID_* (ID_VALID=0 also captures as a bubble with controls forced to 0).
- WB capture bypass: when capturing, if WB_REG_WRITE & WB_RD_ADDR≠0 & WB_RD_ADDR==ID_RSn_ADDR, latch WB_DATA instead of ID_RSn_DATA. This covers the register-file same-cycle write/read.
- EX forwarding, combinational on the registered operands, per source n:
  - x0 is never forwarded; the stored value is used.
  - If MEM_REG_WRITE & ~MEM_MEM_READ & MEM_RD_ADDR==rsn → MEM_ALU_RESULT.
  - Else if WB_REG_WRITE & WB_RD_ADDR==rsn → WB_DATA.
  - Else → stored value.
  - MEM has priority over WB (youngest wins).
- Operand mux:
  - ALU_DATA1 = op1_sel ? EX_PC : fwd_rs1.
  - ALU_DATA2 = op2_sel ? imm : fwd_rs2.
  - EX_STORE_DATA = fwd_rs2 always.
- ALU_SELECT is passed through registered, unchanged.
- Latency: 1 cycle ID→EX, with 0-cycle forwarding paths. A load-use hazard costs exactly one bubble.
- Boundary cases:
  - A hazard on both rs1 and rs2 still gives a single stall cycle.
  - FLUSH and HZ together → bubble, STALL=0.
  - RESET asserted during a stall → clear; STALL falls the next cycle because EX_VALID=0.
  - rd=x0 loads never stall.

Decomposition:
- Shared package holds:
  - ALU SELECT localparams: ADD=000000, SLL=000001, SLT=000010, SLTU=000011, XOR=000100, SRL=000101, OR=000110, AND=000111, MUL=001000, SUB=010000, FWD=011xxx.
  - OP1_RS1/OP1_PC and OP2_RS2/OP2_IMM encodings.
  - XLEN and REG_AW.
- One sub-module, fwd_select: a purely combinational per-operand priority mux. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset: RESET=1 for 2 cycles with ID_VALID=1 → EX_VALID=0, EX_REG_WRITE=0, ALU_SELECT=0, STALL=0.
- Plain capture: ADD with rs1=5 (0x10), rs2=6 (0x22), no forwards → next cycle ALU_DATA1=0x10, ALU_DATA2=0x22, ALU_SELECT=0.
- Forward priority: registered rs1=7 with MEM_RD=7 (0xAAAA0000) and WB_RD=7 (0x1234) both writing → ALU_DATA1=0xAAAA0000. Drop MEM_REG_WRITE → ALU_DATA1=0x1234. Same stimulus with rs1=0 → stored value, no forward.
- Load-use: EX holds LW into x3; ID is ADDI using x3 → STALL=1 for 1 cycle, then a bubble in EX (EX_VALID=0); the ADDI enters the following cycle with WB forwarding.
- Flush vs hazard: load-use condition plus FLUSH=1 → STALL=0 and a bubble is loaded.
- WB capture bypass plus I-type: WB writes x9=0x55 in the same cycle as ID reads x9 (stale 0x0), ID_OP2_SEL=1, imm=0xFFFFFFFC → ALU_DATA1=0x55, ALU_DATA2=0xFFFFFFFC.
